acc_regfile_shadow: RTL and testbench

- Parametrised accumulator-centric register file for the Divvy datapath, with configurable data width, depth and accumulator index.
- Adds a shadow bank with a multi-cycle save/restore engine for subroutine context switches.
- Sits between decode (addresses, immediates, enables) and the ALU (ACC operand, second operand).
- Reads are asynchronous; register writes, ACC writes and save/restore copies are synchronous.

---
 rtl/acc_regfile_shadow.sv | 117 +++++++++++
 tb/tb_acc_regfile_shadow.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_regfile_shadow.sv
// Accumulator-centric register file with a shadow bank and a sequential
// save/restore engine used for subroutine context switches.
module acc_regfile_shadow #(
  parameter int unsigned DW      = 8,
  parameter int unsigned RAW     = 4,
  parameter int unsigned ACC_IDX = 14
) (
  input  logic           CLK,
  input  logic           ResetN,
  input  logic [RAW-1:0] ReadAddr,
  input  logic           ReadRegEn,
  output logic [DW-1:0]  ReadDataOut,
  output logic [DW-1:0]  ACCRead,
  input  logic           WriteACCEn,
  input  logic [DW-1:0]  ACCWrite,
  input  logic           WriteRegEn,
  input  logic [RAW-1:0] RegWriteAddr,
  input  logic           SaveReq,
  input  logic           RestoreReq,
  output logic           Busy,
  output logic           Done
);

  localparam int unsigned D = 1 << RAW;
  localparam logic [RAW-1:0] AccAddr  = RAW'(ACC_IDX);
  localparam logic [RAW-1:0] LastAddr = RAW'(D - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } fsmState_e;

  generate
    if (ACC_IDX >= D) begin : gBadAccIdx
      $error("acc_regfile_shadow: ACC_IDX must be below 2**RAW");
    end
  endgenerate

  fsmState_e      state;
  logic [RAW-1:0] copyCnt;
  logic [DW-1:0]  mainRf   [D];
  logic [DW-1:0]  shadowRf [D];
  logic [DW-1:0]  immVal;

  // Immediate is the read pointer zero-extended (or truncated) to DW.
  assign immVal      = DW'(ReadAddr);
  assign ReadDataOut = ReadRegEn ? mainRf[ReadAddr] : immVal;
  assign ACCRead     = mainRf[AccAddr];

  // Register writes, request acceptance and one-entry-per-cycle copies.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      copyCnt <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      for (int i = 0; i < int'(D); i++) begin
        mainRf[RAW'(i)]   <= '0;
        shadowRf[RAW'(i)] <= '0;
      end
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          // Later assignment wins, so ACCWrite beats a copy onto ACC itself.
          if (WriteRegEn) begin
            mainRf[RegWriteAddr] <= mainRf[AccAddr];
          end
          if (WriteACCEn) begin
            mainRf[AccAddr] <= ACCWrite;
          end
          if (SaveReq) begin
            state   <= SAVE;
            copyCnt <= '0;
            Busy    <= 1'b1;
          end else if (RestoreReq) begin
            state   <= RESTORE;
            copyCnt <= '0;
            Busy    <= 1'b1;
          end
        end
        SAVE: begin
          shadowRf[copyCnt] <= mainRf[copyCnt];
          if (copyCnt == LastAddr) begin
            state   <= IDLE;
            copyCnt <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end else begin
            copyCnt <= copyCnt + RAW'(1);
          end
        end
        RESTORE: begin
          // ACC is skipped so the subroutine's return value survives.
          if (copyCnt != AccAddr) begin
            mainRf[copyCnt] <= shadowRf[copyCnt];
          end
          if (copyCnt == LastAddr) begin
            state   <= IDLE;
            copyCnt <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end else begin
            copyCnt <= copyCnt + RAW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          copyCnt <= '0;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_regfile_shadow.sv
// Scoreboard bench for acc_regfile_shadow: a reference model pushes expected
// values, observations pop and compare them.
module tb_acc_regfile_shadow;

  localparam int unsigned DW      = 8;
  localparam int unsigned RAW     = 4;
  localparam int unsigned ACC_IDX = 14;
  localparam int unsigned D       = 16;

  logic           CLK;
  logic           ResetN;
  logic [RAW-1:0] ReadAddr;
  logic           ReadRegEn;
  logic [DW-1:0]  ReadDataOut;
  logic [DW-1:0]  ACCRead;
  logic           WriteACCEn;
  logic [DW-1:0]  ACCWrite;
  logic           WriteRegEn;
  logic [RAW-1:0] RegWriteAddr;
  logic           SaveReq;
  logic           RestoreReq;
  logic           Busy;
  logic           Done;

  acc_regfile_shadow #(.DW(DW), .RAW(RAW), .ACC_IDX(ACC_IDX)) dut (
    .CLK          (CLK),
    .ResetN       (ResetN),
    .ReadAddr     (ReadAddr),
    .ReadRegEn    (ReadRegEn),
    .ReadDataOut  (ReadDataOut),
    .ACCRead      (ACCRead),
    .WriteACCEn   (WriteACCEn),
    .ACCWrite     (ACCWrite),
    .WriteRegEn   (WriteRegEn),
    .RegWriteAddr (RegWriteAddr),
    .SaveReq      (SaveReq),
    .RestoreReq   (RestoreReq),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0]  mdlMain   [D];
  logic [7:0]  mdlShadow [D];
  logic [31:0] expQ [$];
  int nChecks = 0;
  int nPass   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else nPass++;
  endtask

  task automatic pushExp(input logic [31:0] v);
    expQ.push_back(v);
  endtask

  task automatic popCheck(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    exp = 'x;
    if (expQ.size() > 0) exp = expQ.pop_front();
    checkVal(tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic readReg(input string tag, input int addr);
    ReadRegEn = 1'b1;
    ReadAddr  = RAW'(addr);
    pushExp(32'(mdlMain[addr]));
    #1;
    popCheck($sformatf("%s_rf%0d", tag, addr), 32'(ReadDataOut));
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < int'(D); i++) readReg(tag, i);
    pushExp(32'(mdlMain[ACC_IDX]));
    popCheck({tag, "_acc"}, 32'(ACCRead));
  endtask

  // One idle-cycle write, mirrored in the model with old-ACC semantics.
  task automatic writeStep(input bit accEn, input logic [7:0] accData,
                           input bit regEn, input int regAddr);
    logic [7:0] oldAcc;
    WriteACCEn   = accEn;
    ACCWrite     = accData;
    WriteRegEn   = regEn;
    RegWriteAddr = RAW'(regAddr);
    oldAcc = mdlMain[ACC_IDX];
    if (regEn) mdlMain[regAddr] = oldAcc;
    if (accEn) mdlMain[ACC_IDX] = accData;
    cyc();
    WriteACCEn = 1'b0;
    WriteRegEn = 1'b0;
  endtask

  // Issue a request, watch Busy/Done over a bounded window, optionally
  // injecting blocked writes and a restore request partway through.
  task automatic runOp(input string tag, input bit save, input bit restore, input int injectAt);
    int busyCnt;
    int doneCnt;
    SaveReq    = save;
    RestoreReq = restore;
    cyc();
    SaveReq    = 1'b0;
    RestoreReq = 1'b0;
    busyCnt = 0;
    doneCnt = 0;
    for (int c = 0; c < 24; c++) begin
      if (Busy) busyCnt++;
      if (Done) doneCnt++;
      WriteACCEn = (c == injectAt);
      ACCWrite   = 8'h99;
      RestoreReq = (c == injectAt);
      cyc();
    end
    WriteACCEn = 1'b0;
    RestoreReq = 1'b0;
    if (save) begin
      for (int i = 0; i < int'(D); i++) mdlShadow[i] = mdlMain[i];
    end else begin
      for (int i = 0; i < int'(D); i++) if (i != int'(ACC_IDX)) mdlMain[i] = mdlShadow[i];
    end
    pushExp(32'd16);
    popCheck({tag, "_busyCycles"}, 32'(busyCnt));
    pushExp(32'd1);
    popCheck({tag, "_donePulses"}, 32'(doneCnt));
  endtask

  initial begin
    int doneCnt;
    ResetN = 1'b0; ReadAddr = '0; ReadRegEn = 1'b1; WriteACCEn = 1'b0;
    ACCWrite = '0; WriteRegEn = 1'b0; RegWriteAddr = '0; SaveReq = 1'b0; RestoreReq = 1'b0;
    for (int i = 0; i < int'(D); i++) begin
      mdlMain[i] = '0;
      mdlShadow[i] = '0;
    end
    cyc(); cyc();

    // Reset state
    readReg("rst", 7);
    pushExp(32'h0); popCheck("rst_acc", 32'(ACCRead));
    pushExp(32'h0); popCheck("rst_busy", 32'(Busy));
    pushExp(32'h0); popCheck("rst_done", 32'(Done));
    ResetN = 1'b1;
    cyc();

    // Immediate path
    ReadRegEn = 1'b0; ReadAddr = 4'hB; pushExp(32'h0B); #1;
    popCheck("imm_B", 32'(ReadDataOut));
    ReadAddr = 4'hF; pushExp(32'h0F); #1;
    popCheck("imm_F", 32'(ReadDataOut));

    // ACC write, ACC copy, same-cycle ordering, ACCWrite winning on ACC_IDX
    writeStep(1'b1, 8'h5A, 1'b0, 0);
    writeStep(1'b0, 8'h00, 1'b1, 3);
    readReg("accCopy", 3);
    writeStep(1'b1, 8'h77, 1'b1, 2);
    readReg("sameCyc", 2);
    pushExp(32'h77); popCheck("sameCyc_acc", 32'(ACCRead));
    writeStep(1'b1, 8'h33, 1'b1, ACC_IDX);
    pushExp(32'h33); popCheck("accIdxWin_acc", 32'(ACCRead));

    // Save/restore round trip
    for (int i = 0; i < int'(D); i++) begin
      writeStep(1'b1, 8'(i + 1), 1'b0, 0);
      if (i != int'(ACC_IDX)) writeStep(1'b0, 8'h00, 1'b1, i);
    end
    writeStep(1'b1, 8'h0F, 1'b0, 0);
    runOp("save1", 1'b1, 1'b0, -1);
    checkAll("afterSave");
    writeStep(1'b1, 8'hFF, 1'b0, 0);
    for (int i = 0; i < int'(D); i++) if (i != int'(ACC_IDX)) writeStep(1'b0, 8'h00, 1'b1, i);
    writeStep(1'b1, 8'h42, 1'b0, 0);
    runOp("restore1", 1'b0, 1'b1, -1);
    checkAll("afterRestore");

    // Writes and requests while busy are dropped
    writeStep(1'b1, 8'h21, 1'b0, 0);
    runOp("blocked", 1'b1, 1'b0, 3);
    pushExp(32'h21); popCheck("blocked_acc", 32'(ACCRead));

    // Save has priority; verify the shadow through a later restore
    writeStep(1'b1, 8'hC3, 1'b1, 5);
    runOp("prio", 1'b1, 1'b1, -1);
    checkAll("prioMain");
    writeStep(1'b1, 8'h00, 1'b1, 5);
    writeStep(1'b0, 8'h00, 1'b1, 0);
    runOp("prioRestore", 1'b0, 1'b1, -1);
    checkAll("prioShadow");

    // Reset mid-save
    SaveReq = 1'b1; cyc(); SaveReq = 1'b0;
    repeat (5) cyc();
    ResetN = 1'b0; #1;
    pushExp(32'h0); popCheck("midRst_busy", 32'(Busy));
    for (int i = 0; i < int'(D); i++) begin
      mdlMain[i] = '0;
      mdlShadow[i] = '0;
    end
    cyc();
    ResetN = 1'b1;
    checkAll("midRst");
    doneCnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (Done || Busy) doneCnt++;
      cyc();
    end
    pushExp(32'h0); popCheck("midRst_noDone", 32'(doneCnt));

    // Normal save after reset, verified by restore
    writeStep(1'b1, 8'h3C, 1'b1, 5);
    runOp("postRstSave", 1'b1, 1'b0, -1);
    writeStep(1'b1, 8'h00, 1'b1, 5);
    runOp("postRstRestore", 1'b0, 1'b1, -1);
    checkAll("postRst");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
